// File: rtl/scan7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package scan7_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_t;

    // Special character codes (0..15 are hex digits).
    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;

    // Segment g alone, used for the dash character, {a,b,c,d,e,f,g}.
    localparam logic [6:0] GLYPH_DASH = 7'b000_0001;

    // Hex glyphs {a,b,c,d,e,f,g}; element k is the glyph for digit k.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E d C
        7'h1F, 7'h77, 7'h7B, 7'h7F,   // b A 9 8
        7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
        7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
    };

endpackage

// File: rtl/scan_7seg_ctrl_seg7_decode.sv
// Combinational character decoder: {code, dp, blank} -> active-high {a..g,dp}.
module seg7_decode
    import scan7_pkg::*;
(
    input  logic [4:0] i_code,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    // Glyph lookup; a blanked digit drops both the glyph and the decimal point.
    always_comb begin
        o_seg = 8'h00;
        if (i_blank) begin
            o_seg = 8'h00;
        end else if (i_code < CODE_DASH) begin
            o_seg = {GLYPHS[i_code[3:0]], i_dp};
        end else if (i_code == CODE_DASH) begin
            o_seg = {GLYPH_DASH, i_dp};
        end else begin
            o_seg = {7'b000_0000, i_dp};
        end
    end

endmodule

// File: rtl/scan_7seg_ctrl.sv
// Time-multiplexed 7-segment display scanner with a writable digit bank,
// optional anti-ghosting gap, leading-zero suppression and output polarity.
module scan_7seg_ctrl
    import scan7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [4:0]                    wr_data,
    input  logic                          wr_dp,
    input  logic                          lz_supp,
    output logic [7:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int AW       = $clog2(NUM_DIGITS);
    localparam int CW       = $clog2(REFRESH_DIV + 1);
    localparam int SHOW_LEN = REFRESH_DIV - BLANK_CYCLES;

    localparam logic [CW-1:0]         LP_CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         LP_SHOW_LAST = CW'(SHOW_LEN - 1);
    localparam logic [AW-1:0]         LP_IDX_LAST  = AW'(NUM_DIGITS - 1);
    localparam logic [AW:0]           LP_ND        = (AW + 1)'(NUM_DIGITS);
    localparam logic                  LP_SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic                  LP_AN_INV    = (AN_ACTIVE_LOW != 0);
    localparam logic [7:0]            LP_SEG_OFF   = {8{LP_SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] LP_AN_OFF    = {NUM_DIGITS{LP_AN_INV}};

    logic [4:0]            r_code [NUM_DIGITS];
    logic                  r_dp   [NUM_DIGITS];
    scan_state_t           r_state;
    scan_state_t           w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic [AW-1:0]         r_idx;
    logic [AW-1:0]         w_idx_next;
    logic                  w_entry;
    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic [7:0]            w_dec;
    logic [7:0]            r_pipe;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_tick;

    // Digit register bank; out-of-range addresses are dropped, reset wins over writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_code[i] <= CODE_BLANK;
                r_dp[i]   <= 1'b0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < LP_ND)) begin
            r_code[wr_addr] <= wr_data;
            r_dp[wr_addr]   <= wr_dp;
        end
    end

    // Leading-zero mask: digit i>0 is dark when it and every higher digit hold a bare zero.
    always_comb begin
        logic v_tail;
        w_lz_blank = '0;
        v_tail     = lz_supp;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_tail        = v_tail & (r_code[i] == 5'd0) & ~r_dp[i];
            w_lz_blank[i] = v_tail;
        end
    end

    // Decode the digit that will be driven after the coming edge.
    seg7_decode u_decode (
        .i_code  (r_code[w_idx_next]),
        .i_dp    (r_dp[w_idx_next]),
        .i_blank (w_lz_blank[w_idx_next]),
        .o_seg   (w_dec)
    );

    // Next-state logic: slot timing, digit advance and the enable override.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_entry      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_next = ST_SHOW;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_entry      = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
            end
            ST_SHOW, ST_GAP: begin
                if (!en) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_next = ST_SHOW;
                    w_cnt_next   = '0;
                    w_idx_next   = (r_idx == LP_IDX_LAST) ? '0 : r_idx + 1'b1;
                    w_entry      = 1'b1;
                end else if ((r_state == ST_SHOW) && (r_cnt == LP_SHOW_LAST)) begin
                    w_state_next = ST_GAP;
                    w_cnt_next   = r_cnt + 1'b1;
                end else begin
                    w_state_next = r_state;
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // FSM state, slot counter and digit index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Output registers; mid-slot seg follows the decode pipeline so writes land two edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= 8'h00;
            r_seg  <= LP_SEG_OFF;
            r_an   <= LP_AN_OFF;
            r_tick <= 1'b0;
        end else begin
            r_pipe <= w_dec;
            r_tick <= w_entry & (w_idx_next == '0);
            if (w_state_next == ST_SHOW) begin
                r_an  <= (NUM_DIGITS'(1) << w_idx_next) ^ LP_AN_OFF;
                r_seg <= (w_entry ? w_dec : r_pipe) ^ LP_SEG_OFF;
            end else begin
                r_an  <= LP_AN_OFF;
                r_seg <= LP_SEG_OFF;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign digit_idx  = r_idx;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_scan_7seg_ctrl.sv
// Directed self-checking bench for scan_7seg_ctrl (4 digits, 8-cycle slots, 2-cycle gap).
module tb_scan_7seg_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic       wr_dp;
    logic       lz_supp;
    logic [7:0] seg;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic       frame_tick;

    int n_vec = 0;
    int n_err = 0;

    scan_7seg_ctrl #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (0),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .lz_supp    (lz_supp),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_an, input logic [7:0] e_seg,
                             input logic [1:0] e_idx, input logic e_ft);
        check({tag, ".an"}, 32'(an), 32'(e_an));
        check({tag, ".seg"}, 32'(seg), 32'(e_seg));
        check({tag, ".idx"}, 32'(digit_idx), 32'(e_idx));
        check({tag, ".ft"}, 32'(frame_tick), 32'(e_ft));
    endtask

    task automatic write(input logic [1:0] a, input logic [4:0] d, input logic p);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_dp   = p;
        tick_n(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = 2'd0;
        wr_data = 5'd0; wr_dp = 1'b0; lz_supp = 1'b0;
        tick_n(2);
        check_out("reset", 4'b1111, 8'h00, 2'd0, 1'b0);

        // Load 1,2,3,4 into digits 0..3 while idle.
        rst = 1'b0;
        write(2'd0, 5'd1, 1'b0);
        write(2'd1, 5'd2, 1'b0);
        write(2'd2, 5'd3, 1'b0);
        write(2'd3, 5'd4, 1'b0);
        check_out("idle", 4'b1111, 8'h00, 2'd0, 1'b0);

        // First frame: 6 cycles SHOW, 2 cycles GAP per digit.
        en = 1'b1;
        tick_n(1);
        check_out("d0_entry", 4'b1110, 8'h60, 2'd0, 1'b1);
        for (int k = 1; k < 6; k++) begin
            tick_n(1);
            check("d0_show.an", 32'(an), 32'(4'b1110));
            check("d0_show.ft", 32'(frame_tick), 32'(1'b0));
        end
        tick_n(1);
        check_out("d0_gap_a", 4'b1111, 8'h00, 2'd0, 1'b0);
        tick_n(1);
        check_out("d0_gap_b", 4'b1111, 8'h00, 2'd0, 1'b0);
        tick_n(1);
        check_out("d1_entry", 4'b1101, 8'hDA, 2'd1, 1'b0);
        tick_n(8);
        check_out("d2_entry", 4'b1011, 8'hF2, 2'd2, 1'b0);
        tick_n(8);
        check_out("d3_entry", 4'b0111, 8'h66, 2'd3, 1'b0);
        tick_n(7);
        check("pre_wrap.ft", 32'(frame_tick), 32'(1'b0));
        tick_n(1);
        check_out("frame2", 4'b1110, 8'h60, 2'd0, 1'b1);

        // Write 9 to digit 0 while it is shown; seg changes two edges after the write edge.
        tick_n(1);
        write(2'd0, 5'd9, 1'b0);
        check("wr_lat0.seg", 32'(seg), 32'(8'h60));
        tick_n(1);
        check("wr_lat1.seg", 32'(seg), 32'(8'h60));
        tick_n(1);
        check("wr_lat2.seg", 32'(seg), 32'(8'hF6));

        // Disable during digit 2, then re-enable.
        tick_n(12);
        check_out("d2_again", 4'b1011, 8'hF2, 2'd2, 1'b0);
        tick_n(1);
        en = 1'b0;
        tick_n(1);
        check_out("dis", 4'b1111, 8'h00, 2'd0, 1'b0);
        tick_n(1);
        check_out("dis_hold", 4'b1111, 8'h00, 2'd0, 1'b0);
        en = 1'b1;
        tick_n(1);
        check_out("reen", 4'b1110, 8'hF6, 2'd0, 1'b1);

        // Leading-zero suppression with {3:0, 2:0, 1:5, 0:0}.
        en = 1'b0;
        tick_n(1);
        write(2'd3, 5'd0, 1'b0);
        write(2'd2, 5'd0, 1'b0);
        write(2'd1, 5'd5, 1'b0);
        write(2'd0, 5'd0, 1'b0);
        lz_supp = 1'b1;
        en = 1'b1;
        tick_n(1);
        check_out("lz_d0", 4'b1110, 8'hFC, 2'd0, 1'b1);
        tick_n(8);
        check_out("lz_d1", 4'b1101, 8'hB6, 2'd1, 1'b0);
        tick_n(8);
        check_out("lz_d2", 4'b1011, 8'h00, 2'd2, 1'b0);
        tick_n(8);
        check_out("lz_d3", 4'b0111, 8'h00, 2'd3, 1'b0);

        // A dp on digit 3 stops suppression for digits 3 and 2.
        write(2'd3, 5'd0, 1'b1);
        tick_n(2);
        check("lz_dp3.seg", 32'(seg), 32'(8'hFD));
        tick_n(5);
        check_out("lz2_d0", 4'b1110, 8'hFC, 2'd0, 1'b1);
        tick_n(16);
        check_out("lz2_d2", 4'b1011, 8'hFC, 2'd2, 1'b0);
        tick_n(8);
        check_out("lz2_d3", 4'b0111, 8'hFD, 2'd3, 1'b0);

        // Dash character.
        write(2'd3, 5'd16, 1'b0);
        tick_n(2);
        check("dash.seg", 32'(seg), 32'(8'h02));

        // Reset mid-slot together with a write: write lost, bank blank, FSM idle.
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'd7; wr_dp = 1'b1;
        tick_n(1);
        check_out("rst_mid", 4'b1111, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        wr_en = 1'b0;
        lz_supp = 1'b0;
        tick_n(1);
        check_out("post_rst_d0", 4'b1110, 8'h00, 2'd0, 1'b1);
        tick_n(8);
        check_out("post_rst_d1", 4'b1101, 8'h00, 2'd1, 1'b0);
        tick_n(8);
        check_out("post_rst_d2", 4'b1011, 8'h00, 2'd2, 1'b0);
        tick_n(8);
        check_out("post_rst_d3", 4'b0111, 8'h00, 2'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
